// File: rtl/apb4_master_bridge.sv
// APB4 requester: single-beat valid/ready commands become SETUP/ACCESS
// transfers, with a bounded wait-state timeout and a registered response.
module apb4_master_bridge #(
   parameter int ADDRWIDTH = 12,
   parameter int TIMEOUT   = 16
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADDRWIDTH-1:0] cmd_addr,
   input  logic [31:0]          cmd_wdata,
   input  logic [3:0]           cmd_strb,
   input  logic [2:0]           cmd_prot,
   output logic                 psel,
   output logic                 penable,
   output logic [ADDRWIDTH-1:0] paddr,
   output logic                 pwrite,
   output logic [31:0]          pwdata,
   output logic [3:0]           pstrb,
   output logic [2:0]           pprot,
   input  logic [31:0]          prdata,
   input  logic                 pready,
   input  logic                 pslverr,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_err,
   output logic                 rsp_timeout
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] CMAX = '1;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          hs;
   logic          timed_out;

   assign cmd_ready = (state == IDLE) && !preset;
   assign hs        = cmd_valid && cmd_ready;

   // wait_cnt holds the number of stalled ACCESS cycles already seen,
   // so the current cycle is the TIMEOUT-th one when it equals LAST.
   assign timed_out = (TIMEOUT != 0) && (wait_cnt == LAST) && !pready;

   always_ff @(posedge pclk) begin
      if (preset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         paddr       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         pstrb       <= '0;
         pprot       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (hs) begin
                  paddr  <= cmd_addr;
                  pwrite <= cmd_write;
                  pwdata <= cmd_write ? cmd_wdata : '0;
                  pstrb  <= cmd_write ? cmd_strb : '0;
                  pprot  <= cmd_prot;
                  psel   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               penable  <= 1'b1;
               wait_cnt <= '0;
               state    <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= pwrite ? '0 : prdata;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  state       <= IDLE;
               end else if (timed_out) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  state       <= IDLE;
               end else if (wait_cnt != CMAX) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Bench for apb4_master_bridge: cycle-age transfer model plus
// directed transfers with hand-computed responses.
module tb_apb4_master_bridge;

   localparam int AW = 12;
   localparam int TO = 4;

   logic          pclk = 1'b0;
   logic          preset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic [3:0]    cmd_strb;
   logic [2:0]    cmd_prot;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [31:0]   pwdata, prdata;
   logic [3:0]    pstrb;
   logic [2:0]    pprot;
   logic          pready, pslverr;
   logic          rsp_valid, rsp_err, rsp_timeout;
   logic [31:0]   rsp_rdata;

   always #5 pclk = ~pclk;

   apb4_master_bridge #(.ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .psel(psel), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
   );

   int checks = 0;
   int fails  = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Transfer model: m_age counts cycles since the handshake
   // (1 = SETUP, k+1 = k-th ACCESS cycle).
   bit            m_busy;
   int            m_age;
   logic [AW-1:0] m_addr;
   logic          m_wr;
   logic [31:0]   m_wdata;
   logic [3:0]    m_strb;
   logic [2:0]    m_prot;
   logic          m_rv, m_err, m_to;
   logic [31:0]   m_rdata;

   always @(posedge pclk) begin
      if (preset) begin
         m_busy <= 0; m_age <= 0;
         m_addr <= '0; m_wr <= 0; m_wdata <= '0;
         m_strb <= '0; m_prot <= '0;
         m_rv <= 0; m_err <= 0; m_to <= 0; m_rdata <= '0;
      end else begin
         m_rv <= 0;
         if (!m_busy) begin
            if (cmd_valid) begin
               m_busy  <= 1; m_age <= 1;
               m_addr  <= cmd_addr; m_wr <= cmd_write;
               m_wdata <= cmd_write ? cmd_wdata : 32'h0;
               m_strb  <= cmd_write ? cmd_strb : 4'h0;
               m_prot  <= cmd_prot;
            end
         end else if (m_age == 1) begin
            m_age <= 2;
         end else if (pready) begin
            m_busy <= 0; m_rv <= 1;
            m_rdata <= m_wr ? 32'h0 : prdata;
            m_err <= pslverr; m_to <= 0;
         end else if (TO != 0 && m_age - 1 == TO) begin
            m_busy <= 0; m_rv <= 1;
            m_rdata <= 32'h0; m_err <= 1; m_to <= 1;
         end else begin
            m_age <= m_age + 1;
         end
      end
   end

   always @(negedge pclk) begin
      if (chk_on) begin
         chk("m_cmd_ready", cmd_ready, !m_busy && !preset);
         chk("m_psel", psel, m_busy);
         chk("m_penable", penable, m_busy && m_age >= 2);
         chk("m_paddr", paddr, m_addr);
         chk("m_pwrite", pwrite, m_wr);
         chk("m_pwdata", pwdata, m_wdata);
         chk("m_pstrb", pstrb, m_strb);
         chk("m_pprot", pprot, m_prot);
         chk("m_rsp_valid", rsp_valid, m_rv);
         chk("m_rsp_rdata", rsp_rdata, m_rdata);
         chk("m_rsp_err", rsp_err, m_err);
         chk("m_rsp_timeout", rsp_timeout, m_to);
      end
   end

   task automatic tick;
      @(posedge pclk);
      #2;
   endtask

   // lat = cycles from handshake to rsp_valid; lat-2 ACCESS cycles.
   task automatic xfer(input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [2:0] pr, input int nwait,
                       input logic err, input logic [31:0] rd,
                       input int lat, input logic [31:0] e_rdata,
                       input logic e_err, input logic e_to);
      cmd_valid = 1; cmd_write = wr; cmd_addr = a;
      cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
      chk("hs_ready", cmd_ready, 1);
      tick;
      cmd_valid = 0; pready = 1; prdata = 32'h1111_2222;
      chk("setup_phase", {psel, penable}, 2'b10);
      chk("setup_addr", paddr, a);
      tick;
      chk("access_strb", pstrb, wr ? st : 4'h0);
      for (int i = 0; i < lat - 2; i++) begin
         chk("access_phase", {psel, penable}, 2'b11);
         pready  = (i == nwait);
         pslverr = (i == nwait) ? err : 1'b0;
         prdata  = (i == nwait) ? rd : (32'hBAD0_0000 | i);
         tick;
      end
      pready = 0; pslverr = 0;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_psel", psel, 0);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_timeout", rsp_timeout, e_to);
      tick;
      chk("rsp_pulse", rsp_valid, 0);
   endtask

   initial begin
      preset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
      cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
      prdata = '0; pready = 0; pslverr = 0;
      tick;
      chk_on = 1;
      chk("rst_psel", psel, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      tick;
      preset = 0;
      #1 chk("rel_cmd_ready", cmd_ready, 1);
      tick;

      // zero-wait write
      xfer(1, 12'h010, 32'hA5A5_1234, 4'hF, 3'h2, 0, 0, 32'h0,
           3, 32'h0, 0, 0);
      // read, 3 wait states
      xfer(0, 12'h024, 32'h7777_7777, 4'hF, 3'h1, 3, 0, 32'hDEAD_BEEF,
           6, 32'hDEAD_BEEF, 0, 0);
      // read with slave error after one wait state
      xfer(0, 12'h030, 32'h0, 4'h0, 3'h0, 1, 1, 32'h0BAD_F00D,
           4, 32'h0BAD_F00D, 1, 0);
      // timeout: pready never rises within 4 ACCESS cycles
      xfer(0, 12'h040, 32'h0, 4'h0, 3'h5, 99, 0, 32'h0,
           6, 32'h0, 1, 1);
      // pready on the 4th ACCESS cycle wins over the timeout
      xfer(1, 12'h044, 32'h0102_0304, 4'h3, 3'h4, 3, 0, 32'h0,
           6, 32'h0, 0, 0);

      begin : b2b
         int hs_cnt;
         int hs_at[3];
         bit took;
         logic [31:0] wdv[3];
         logic        wrv[3];
         hs_cnt = 0;
         wdv[0] = 32'h0000_AAAA; wdv[1] = 32'h0000_BBBB;
         wdv[2] = 32'h0000_CCCC;
         wrv[0] = 1; wrv[1] = 0; wrv[2] = 1;
         pready = 1; prdata = 32'hCAFE_0001;
         cmd_valid = 1; cmd_write = wrv[0]; cmd_addr = 12'h100;
         cmd_wdata = wdv[0]; cmd_strb = 4'hF;
         for (int s = 0; s < 12 && hs_cnt < 3; s++) begin
            took = cmd_ready;
            if (took) begin
               if (hs_cnt > 0) chk("b2b_rsp_with_hs", rsp_valid, 1);
               hs_at[hs_cnt] = s;
               hs_cnt++;
            end
            tick;
            if (took) begin
               if (hs_cnt < 3) begin
                  cmd_write = wrv[hs_cnt];
                  cmd_addr  = 12'h100 + AW'(hs_cnt * 4);
                  cmd_wdata = wdv[hs_cnt];
               end else begin
                  cmd_valid = 0;
               end
            end
         end
         chk("b2b_count", hs_cnt, 3);
         chk("b2b_gap1", hs_at[1] - hs_at[0], 3);
         chk("b2b_gap2", hs_at[2] - hs_at[1], 3);
         tick; tick;
         chk("b2b_last_rsp", rsp_valid, 1);
         chk("b2b_last_rdata", rsp_rdata, 0);
         tick;
      end

      // reset during ACCESS
      pready = 0;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h3F0;
      cmd_wdata = 32'h5555_AAAA; cmd_strb = 4'hC; cmd_prot = 3'h7;
      tick;
      cmd_valid = 0;
      tick;
      chk("mid_access", {psel, penable}, 2'b11);
      preset = 1;
      #1 chk("mid_rst_ready", cmd_ready, 0);
      tick;
      chk("mid_rst_psel", {psel, penable}, 2'b00);
      chk("mid_rst_rsp", rsp_valid, 0);
      preset = 0;
      tick;
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_rsp", rsp_valid, 0);
      tick; tick;

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
